// File: rtl/hidden_layer_sequencer_pkg.sv
// Shared definitions for the hidden-layer sequencer: frame geometry defaults,
// FSM state encoding and the width helper used by the parameter defaults.
package hidden_layer_sequencer_pkg;

    localparam int INPUT_NODES_DEF  = 10;
    localparam int HIDDEN_NODES_DEF = 4;
    localparam int IDX_W_DEF        = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT_Q = 3'd3,
        ST_POP    = 3'd4,
        ST_FETCH  = 3'd5,
        ST_FLUSH  = 3'd6
    } state_t;

    // Ceiling log2, never below 1 so single-entry ranges still get a bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    localparam int HID_W_DEF  = clog2_min1(HIDDEN_NODES_DEF);
    localparam int ADDR_W_DEF = clog2_min1(INPUT_NODES_DEF * HIDDEN_NODES_DEF);

endpackage

// File: rtl/hidden_layer_sequencer_if.sv
// Bundle of the image-source, ILC, weight-RAM and accumulator signals that the
// sequencer drives or observes; master is the sequencer side.
interface hidden_layer_sequencer_if
    import hidden_layer_sequencer_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int HID_W  = HID_W_DEF
);
    logic              start;
    logic              pixel_valid;
    logic              pixel_in;
    logic              pixel_ready;
    logic              ilc_ready_for_inputs;
    logic              ilc_inputs_inbound;
    logic              ilc_pixel_value;
    logic              ilc_outputs_ready;
    logic [IDX_W-1:0]  ilc_index;
    logic              ilc_queue_empty;
    logic              ilc_dequeue;
    logic              weight_rd;
    logic [ADDR_W-1:0] weight_addr;
    logic              acc_clear;
    logic              acc_en;
    logic [HID_W-1:0]  acc_neuron;
    logic              busy;
    logic              done;
    logic              idx_error;

    modport master (
        input  start, pixel_valid, pixel_in, ilc_ready_for_inputs,
               ilc_outputs_ready, ilc_index, ilc_queue_empty,
        output pixel_ready, ilc_inputs_inbound, ilc_pixel_value, ilc_dequeue,
               weight_rd, weight_addr, acc_clear, acc_en, acc_neuron,
               busy, done, idx_error
    );

    modport slave (
        output start, pixel_valid, pixel_in, ilc_ready_for_inputs,
               ilc_outputs_ready, ilc_index, ilc_queue_empty,
        input  pixel_ready, ilc_inputs_inbound, ilc_pixel_value, ilc_dequeue,
               weight_rd, weight_addr, acc_clear, acc_en, acc_neuron,
               busy, done, idx_error
    );

endinterface

// File: rtl/hidden_layer_sequencer_fetch_counter.sv
// Per-index weight fetch: steps the neuron counter, forms idx*HIDDEN_NODES+h
// and delays the read strobe by one stage so accumulation lines up with RAM data.
module hidden_layer_sequencer_fetch_counter
    import hidden_layer_sequencer_pkg::*;
#(
    parameter int HIDDEN_NODES = HIDDEN_NODES_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int HID_W        = clog2_min1(HIDDEN_NODES),
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    output logic              last,
    output logic              weight_rd,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              acc_en,
    output logic [HID_W-1:0]  acc_neuron
);
    localparam int               PROD_W = IDX_W + HID_W + 1;
    localparam logic [HID_W-1:0] H_LAST = HID_W'(HIDDEN_NODES - 1);

    logic [HID_W-1:0] h_reg;
    logic             acc_en_reg;
    logic [HID_W-1:0] acc_neuron_reg;

    assign last        = step && (h_reg == H_LAST);
    assign weight_rd   = step && rd_en;
    assign weight_addr = ADDR_W'(PROD_W'(idx) * PROD_W'(HIDDEN_NODES) + PROD_W'(h_reg));
    assign acc_en      = acc_en_reg;
    assign acc_neuron  = acc_neuron_reg;

    // h wraps to 0 on the last neuron, so every FETCH burst starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg          <= '0;
            acc_en_reg     <= 1'b0;
            acc_neuron_reg <= '0;
        end else begin
            if (step) begin
                h_reg <= last ? '0 : h_reg + 1'b1;
            end
            acc_en_reg     <= step && rd_en;
            acc_neuron_reg <= h_reg;
        end
    end

endmodule

// File: rtl/hidden_layer_sequencer.sv
// Frame sequencer: loads one binary image into the ILC, drains its index queue
// and issues HIDDEN_NODES weight reads plus accumulator strobes per index.
module hidden_layer_sequencer
    import hidden_layer_sequencer_pkg::*;
#(
    parameter int INPUT_NODES  = INPUT_NODES_DEF,
    parameter int HIDDEN_NODES = HIDDEN_NODES_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int HID_W        = clog2_min1(HIDDEN_NODES),
    parameter int ADDR_W       = clog2_min1(INPUT_NODES * HIDDEN_NODES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hidden_layer_sequencer_if.master  bus
);
    localparam int               PIX_W     = clog2_min1(INPUT_NODES);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(INPUT_NODES - 1);
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(INPUT_NODES);

    state_t           state_reg, state_next;
    logic [PIX_W-1:0] pix_cnt_reg, pix_cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             idx_error_reg, idx_error_next;
    logic             done_reg, done_next;
    logic             fetch_step;
    logic             fetch_rd;
    logic             fetch_last;
    logic             idx_bad;

    assign idx_bad       = (idx_reg >= IDX_LIMIT);
    assign bus.done      = done_reg;
    assign bus.idx_error = idx_error_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pix_cnt_reg   <= '0;
            idx_reg       <= '0;
            idx_error_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pix_cnt_reg   <= pix_cnt_next;
            idx_reg       <= idx_next;
            idx_error_reg <= idx_error_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next             = state_reg;
        pix_cnt_next           = pix_cnt_reg;
        idx_next               = idx_reg;
        idx_error_next         = idx_error_reg;
        done_next              = 1'b0;
        fetch_step             = 1'b0;
        fetch_rd               = 1'b0;
        bus.pixel_ready        = 1'b0;
        bus.ilc_inputs_inbound = 1'b0;
        bus.ilc_pixel_value    = 1'b0;
        bus.ilc_dequeue        = 1'b0;
        bus.acc_clear          = 1'b0;
        bus.busy               = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (bus.start && bus.ilc_ready_for_inputs) begin
                    idx_error_next = 1'b0;
                    state_next     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bus.acc_clear = 1'b1;
                pix_cnt_next  = '0;
                state_next    = ST_LOAD;
            end
            ST_LOAD: begin
                bus.pixel_ready        = 1'b1;
                bus.ilc_inputs_inbound = 1'b1;
                if (bus.pixel_valid) begin
                    bus.ilc_pixel_value = bus.pixel_in;
                    if (pix_cnt_reg == PIX_LAST) begin
                        pix_cnt_next = '0;
                        state_next   = ST_WAIT_Q;
                    end else begin
                        pix_cnt_next = pix_cnt_reg + 1'b1;
                    end
                end
            end
            ST_WAIT_Q: begin
                if (bus.ilc_outputs_ready) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                if (bus.ilc_queue_empty) begin
                    state_next = ST_FLUSH;
                end else begin
                    bus.ilc_dequeue = 1'b1;
                    idx_next        = bus.ilc_index;
                    if (bus.ilc_index >= IDX_LIMIT) begin
                        idx_error_next = 1'b1;
                    end
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Out-of-range indices still spend their cycles but touch no RAM.
                fetch_step = 1'b1;
                fetch_rd   = !idx_bad;
                if (fetch_last) begin
                    state_next = ST_POP;
                end
            end
            ST_FLUSH: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    hidden_layer_sequencer_fetch_counter #(
        .HIDDEN_NODES (HIDDEN_NODES),
        .IDX_W        (IDX_W),
        .HID_W        (HID_W),
        .ADDR_W       (ADDR_W)
    ) u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .step         (fetch_step),
        .rd_en        (fetch_rd),
        .idx          (idx_reg),
        .last         (fetch_last),
        .weight_rd    (bus.weight_rd),
        .weight_addr  (bus.weight_addr),
        .acc_en       (bus.acc_en),
        .acc_neuron   (bus.acc_neuron)
    );

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Bench for hidden_layer_sequencer with a behavioural ILC, a 1-cycle weight RAM
// and hidden accumulators; read addresses/neurons are scoreboarded.
module tb_hidden_layer_sequencer;
    import hidden_layer_sequencer_pkg::*;

    localparam int IN_N   = 10;
    localparam int HN     = 4;
    localparam int IDX_W  = 10;
    localparam int HID_W  = 2;
    localparam int ADDR_W = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hidden_layer_sequencer_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .HID_W(HID_W)) bus ();

    hidden_layer_sequencer #(
        .INPUT_NODES(IN_N), .HIDDEN_NODES(HN), .IDX_W(IDX_W), .HID_W(HID_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int exp_neuron[$];
    int exp_acc[HN];
    int acc_model[HN];
    int ram_q;
    int ilc_q[$];
    int m_cnt;
    int bad_pix = -1;
    int n_rd, n_deq, n_clear, n_done, n_inbound;

    function automatic int weight_of(input int a);
        return (a * 7 + 3) % 251;
    endfunction

    function automatic logic [17:0] out_vec();
        return {bus.pixel_ready, bus.ilc_inputs_inbound, bus.ilc_pixel_value, bus.ilc_dequeue,
                bus.weight_rd, bus.weight_addr, bus.acc_clear, bus.acc_en, bus.acc_neuron,
                bus.busy, bus.done, bus.idx_error};
    endfunction

    // Behavioural ILC: records active-pixel indices, serves them head-first.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ilc_q.delete();
            m_cnt = 0;
            bus.ilc_outputs_ready <= 1'b0;
            bus.ilc_queue_empty   <= 1'b1;
            bus.ilc_index         <= '0;
        end else begin
            if (bus.acc_clear) begin
                ilc_q.delete();
                m_cnt = 0;
                bus.ilc_outputs_ready <= 1'b0;
            end
            if (bus.ilc_inputs_inbound && bus.pixel_valid) begin
                if (bus.ilc_pixel_value) ilc_q.push_back((m_cnt == bad_pix) ? 12 : m_cnt);
                m_cnt = m_cnt + 1;
                if (m_cnt == IN_N) bus.ilc_outputs_ready <= 1'b1;
            end
            if (bus.ilc_dequeue && ilc_q.size() > 0) void'(ilc_q.pop_front());
            bus.ilc_queue_empty <= (ilc_q.size() == 0);
            bus.ilc_index       <= (ilc_q.size() > 0) ? IDX_W'(ilc_q[0]) : '0;
        end
    end

    // Weight RAM (1-cycle read) and hidden accumulators.
    initial forever begin
        @(posedge clk);
        if (bus.weight_rd) ram_q <= weight_of(int'(bus.weight_addr));
        if (bus.acc_clear) for (int h = 0; h < HN; h++) acc_model[h] = 0;
        if (bus.acc_en) acc_model[bus.acc_neuron] = acc_model[bus.acc_neuron] + ram_q;
    end

    // Scoreboard and event counters, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.weight_rd) begin
                n_rd++;
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++; $display("FAIL sb_addr got %0d required none", bus.weight_addr);
                end else begin
                    int e;
                    e = exp_addr.pop_front();
                    if (int'(bus.weight_addr) !== e) begin
                        errors++; $display("FAIL sb_addr got %0d required %0d", bus.weight_addr, e);
                    end
                end
            end
            if (bus.acc_en) begin
                checks++;
                if (exp_neuron.size() == 0) begin
                    errors++; $display("FAIL sb_neuron got %0d required none", bus.acc_neuron);
                end else begin
                    int e;
                    e = exp_neuron.pop_front();
                    if (int'(bus.acc_neuron) !== e) begin
                        errors++; $display("FAIL sb_neuron got %0d required %0d", bus.acc_neuron, e);
                    end
                end
            end
            if (bus.ilc_dequeue) begin
                n_deq++;
                checks++;
                if (bus.ilc_queue_empty !== 1'b0) begin
                    errors++; $display("FAIL dequeue_on_empty got empty=%0b required 0", bus.ilc_queue_empty);
                end
            end
            if (bus.acc_clear) n_clear++;
            if (bus.done) n_done++;
            if (bus.ilc_inputs_inbound) n_inbound++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        n_rd = 0; n_deq = 0; n_clear = 0; n_done = 0; n_inbound = 0;
        exp_addr.delete();
        exp_neuron.delete();
        for (int h = 0; h < HN; h++) exp_acc[h] = 0;
    endtask

    task automatic start_frame(input logic [0:IN_N-1] pix, input bit toggle, input int bad,
                               output int accepted);
        logic v;
        logic phase;
        clear_stats();
        bad_pix = bad;
        for (int i = 0; i < IN_N; i++) begin
            if (pix[i]) begin
                int idx;
                idx = (i == bad) ? 12 : i;
                if (idx < IN_N) begin
                    for (int h = 0; h < HN; h++) begin
                        exp_addr.push_back(idx * HN + h);
                        exp_neuron.push_back(h);
                        exp_acc[h] += weight_of(idx * HN + h);
                    end
                end
            end
        end
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        phase = 1'b0;
        accepted = 0;
        for (int c = 0; c < 100 && accepted < IN_N; c++) begin
            if (bus.pixel_ready) begin
                v = toggle ? phase : 1'b1;
                phase = ~phase;
                bus.pixel_valid = v;
                bus.pixel_in    = pix[accepted];
                if (v) accepted++;
            end else begin
                bus.pixel_valid = 1'b0;
                bus.pixel_in    = 1'b0;
            end
            @(negedge clk);
        end
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = 1'b0;
    endtask

    task automatic wait_done(input bit pulse_start, output bit seen, output int lat,
                             output logic busy_at, output logic busy_before);
        logic prev_busy;
        bit   pulsed;
        int   tail;
        seen = 0; lat = -1; busy_at = 1'bx; busy_before = 1'bx;
        prev_busy = bus.busy; pulsed = 0; tail = 0;
        for (int c = 0; c < 300 && tail < 3; c++) begin
            if (seen) tail++;
            if (bus.done && !seen) begin
                seen = 1; lat = c; busy_at = bus.busy; busy_before = prev_busy;
            end
            if (pulse_start && bus.weight_rd && !pulsed) begin
                bus.start = 1'b1; pulsed = 1;
            end else begin
                bus.start = 1'b0;
            end
            prev_busy = bus.busy;
            @(negedge clk);
        end
        bus.start = 1'b0;
        $display("frame: reads %0d pops %0d clears %0d dones %0d inbound %0d", n_rd, n_deq, n_clear, n_done, n_inbound);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.pixel_valid = 1'b0; bus.pixel_in = 1'b0; bus.ilc_ready_for_inputs = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_vec() !== '0) begin errors++; $display("FAIL reset_outputs got %h required 0", out_vec()); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b required 0", bus.busy); end
        clear_stats();
        bus.ilc_ready_for_inputs = 1'b0;
        bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (n_clear !== 0) begin errors++; $display("FAIL dropped_start_clear got %0d required 0", n_clear); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dropped_start_busy got %0b required 0", bus.busy); end
        bus.ilc_ready_for_inputs = 1'b1;
    endtask

    task automatic test_sparse_frame();
        int acc_n, lat; bit seen; logic b_at, b_before;
        start_frame(10'b1101101100, 1'b0, -1, acc_n);
        wait_done(1'b0, seen, lat, b_at, b_before);
        checks++; if (acc_n != IN_N) begin errors++; $display("FAIL t1_accepted got %0d required %0d", acc_n, IN_N); end
        checks++; if (!seen) begin errors++; $display("FAIL t1_done got none required pulse"); end
        checks++; if (n_rd != 24) begin errors++; $display("FAIL t1_reads got %0d required 24", n_rd); end
        checks++; if (n_deq != 6) begin errors++; $display("FAIL t1_pops got %0d required 6", n_deq); end
        checks++; if (n_clear != 1) begin errors++; $display("FAIL t1_clears got %0d required 1", n_clear); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL t1_dones got %0d required 1", n_done); end
        checks++; if (n_inbound != 10) begin errors++; $display("FAIL t1_inbound got %0d required 10", n_inbound); end
        checks++; if (exp_addr.size() != 0) begin errors++; $display("FAIL t1_sb_left got %0d required 0", exp_addr.size()); end
        checks++; if (b_at !== 1'b0 || b_before !== 1'b1) begin errors++; $display("FAIL t1_busy_fall got %0b%0b required 10", b_before, b_at); end
        for (int h = 0; h < HN; h++) begin
            checks++; if (acc_model[h] != exp_acc[h]) begin errors++; $display("FAIL t1_acc%0d got %0d required %0d", h, acc_model[h], exp_acc[h]); end
        end
    endtask

    task automatic test_all_zero();
        int acc_n, lat; bit seen; logic b_at, b_before;
        start_frame(10'b0000000000, 1'b0, -1, acc_n);
        wait_done(1'b0, seen, lat, b_at, b_before);
        checks++; if (n_rd != 0) begin errors++; $display("FAIL t2_reads got %0d required 0", n_rd); end
        checks++; if (n_clear != 1) begin errors++; $display("FAIL t2_clears got %0d required 1", n_clear); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL t2_dones got %0d required 1", n_done); end
        // inbound falls -> one WAIT_Q cycle -> POP -> FLUSH -> done
        checks++; if (lat != 3) begin errors++; $display("FAIL t2_done_latency got %0d required 3", lat); end
    endtask

    task automatic test_toggle_valid();
        int acc_n, lat; bit seen; logic b_at, b_before;
        start_frame(10'b0110010011, 1'b1, -1, acc_n);
        wait_done(1'b0, seen, lat, b_at, b_before);
        checks++; if (acc_n != IN_N) begin errors++; $display("FAIL t3_accepted got %0d required %0d", acc_n, IN_N); end
        checks++; if (n_inbound != 20) begin errors++; $display("FAIL t3_inbound got %0d required 20", n_inbound); end
        checks++; if (n_rd != 20) begin errors++; $display("FAIL t3_reads got %0d required 20", n_rd); end
        checks++; if (exp_addr.size() != 0) begin errors++; $display("FAIL t3_sb_left got %0d required 0", exp_addr.size()); end
        for (int h = 0; h < HN; h++) begin
            checks++; if (acc_model[h] != exp_acc[h]) begin errors++; $display("FAIL t3_acc%0d got %0d required %0d", h, acc_model[h], exp_acc[h]); end
        end
    endtask

    task automatic test_start_in_fetch();
        int acc_n, lat; bit seen; logic b_at, b_before;
        start_frame(10'b1000000001, 1'b0, -1, acc_n);
        wait_done(1'b1, seen, lat, b_at, b_before);
        checks++; if (n_clear != 1) begin errors++; $display("FAIL t4_clears got %0d required 1", n_clear); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL t4_dones got %0d required 1", n_done); end
        checks++; if (n_rd != 8) begin errors++; $display("FAIL t4_reads got %0d required 8", n_rd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t4_idle_after got %0b required 0", bus.busy); end
    endtask

    task automatic test_reset_mid_fetch();
        int acc_n, lat; bit seen; logic b_at, b_before;
        start_frame(10'b1101101100, 1'b0, -1, acc_n);
        for (int c = 0; c < 100 && n_rd < 5; c++) @(negedge clk);
        checks++; if (bus.weight_rd !== 1'b1) begin errors++; $display("FAIL t5_in_fetch got %0b required 1", bus.weight_rd); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_vec() !== '0) begin errors++; $display("FAIL t5_async_outputs got %h required 0", out_vec()); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL t5_no_done got %0d required 0", n_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame(10'b1101101100, 1'b0, -1, acc_n);
        wait_done(1'b0, seen, lat, b_at, b_before);
        checks++; if (n_rd != 24) begin errors++; $display("FAIL t5_reads got %0d required 24", n_rd); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL t5_dones got %0d required 1", n_done); end
        checks++; if (exp_addr.size() != 0) begin errors++; $display("FAIL t5_sb_left got %0d required 0", exp_addr.size()); end
        for (int h = 0; h < HN; h++) begin
            checks++; if (acc_model[h] != exp_acc[h]) begin errors++; $display("FAIL t5_acc%0d got %0d required %0d", h, acc_model[h], exp_acc[h]); end
        end
    endtask

    task automatic test_bad_index();
        int acc_n, lat; bit seen; logic b_at, b_before;
        start_frame(10'b1101101100, 1'b0, 3, acc_n);
        wait_done(1'b0, seen, lat, b_at, b_before);
        checks++; if (bus.idx_error !== 1'b1) begin errors++; $display("FAIL t6_idx_error got %0b required 1", bus.idx_error); end
        checks++; if (n_rd != 20) begin errors++; $display("FAIL t6_reads got %0d required 20", n_rd); end
        checks++; if (n_deq != 6) begin errors++; $display("FAIL t6_pops got %0d required 6", n_deq); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL t6_dones got %0d required 1", n_done); end
        for (int h = 0; h < HN; h++) begin
            checks++; if (acc_model[h] != exp_acc[h]) begin errors++; $display("FAIL t6_acc%0d got %0d required %0d", h, acc_model[h], exp_acc[h]); end
        end
        bad_pix = -1;
        start_frame(10'b0010000000, 1'b0, -1, acc_n);
        checks++; if (bus.idx_error !== 1'b0) begin errors++; $display("FAIL t6_error_cleared got %0b required 0", bus.idx_error); end
        wait_done(1'b0, seen, lat, b_at, b_before);
        checks++; if (n_rd != 4) begin errors++; $display("FAIL t6_next_reads got %0d required 4", n_rd); end
        checks++; if (exp_addr.size() != 0) begin errors++; $display("FAIL t6_sb_left got %0d required 0", exp_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_sparse_frame();
        test_all_zero();
        test_toggle_valid();
        test_start_in_fetch();
        test_reset_mid_fetch();
        test_bad_index();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
